// File: rtl/axi4_lite_instr_loader.sv
// AXI4-Lite slave that loads instruction memory and gates run_pc for the RISC-V core.
// Optional LOADER_READBACK_EN adds a 256x32 shadow RAM so the IMEM window can be read back.
module axi4_lite_instr_loader #(
    parameter int MEM_RST_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [10:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic        instruction_write,
    output logic [31:0] instruction_data,
    output logic [7:0]  instruction_addr,
    output logic        run_pc,
    output logic        mem_reset_n
);

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [7:0] REG_CTRL    = 8'h00;
    localparam logic [7:0] REG_STATUS  = 8'h01;
    localparam logic [7:0] REG_LIMIT   = 8'h02;
    localparam logic [7:0] REG_COUNT   = 8'h03;
    localparam logic [7:0] MEMRST_LOAD = 8'(MEM_RST_CYCLES);

    // Every channel transfers on a rising edge where valid and ready are both high;
    // a source holds valid and payload stable until that edge.
    w_state_t    w_state_q, w_state_d;
    logic        aw_done_q, aw_done_d;
    logic [8:0]  awaddr_q,  awaddr_d;
    logic        w_done_q,  w_done_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [3:0]  wstrb_q,   wstrb_d;
    logic        awready_q, awready_d;
    logic        wready_q,  wready_d;
    logic        bvalid_q,  bvalid_d;
    logic [1:0]  bresp_q,   bresp_d;

    r_state_t    r_state_q, r_state_d;
    logic        arready_q, arready_d;
    logic        rvalid_q,  rvalid_d;
    logic [31:0] rdata_q,   rdata_d;
    logic [1:0]  rresp_q,   rresp_d;

    logic        imem_wr_q,   imem_wr_d;
    logic [31:0] imem_data_q, imem_data_d;
    logic [7:0]  imem_addr_q, imem_addr_d;

    logic        running_q,   running_d;
    logic        done_q,      done_d;
    logic [31:0] limit_q,     limit_d;
    logic [31:0] run_limit_q, run_limit_d;
    logic [31:0] count_q,     count_d;
    logic [7:0]  memrst_cnt_q, memrst_cnt_d;
    logic        mem_reset_n_q, mem_reset_n_d;

    logic        aw_hs, w_hs;
    logic [8:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        memrst_busy;

    logic        unused_addr_bits;
    assign unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};

`ifdef LOADER_READBACK_EN
    logic [31:0] shadow_mem [256];

    // Contents deliberately survive reset; only successful IMEM writes update it.
    always_ff @(posedge clk) begin
        if (!reset && imem_wr_d) begin
            shadow_mem[imem_addr_d] <= imem_data_d;
        end
    end
`endif

    assign memrst_busy = (memrst_cnt_q != 8'd0);

    always_comb begin
        w_state_d    = w_state_q;
        aw_done_d    = aw_done_q;
        awaddr_d     = awaddr_q;
        w_done_d     = w_done_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        imem_wr_d    = 1'b0;
        imem_data_d  = imem_data_q;
        imem_addr_d  = imem_addr_q;
        running_d    = running_q;
        done_d       = done_q;
        limit_d      = limit_q;
        run_limit_d  = run_limit_q;
        count_d      = count_q;
        memrst_cnt_d = memrst_cnt_q;

        aw_hs   = s_awvalid && awready_q;
        w_hs    = s_wvalid && wready_q;
        wr_addr = aw_done_q ? awaddr_q : s_awaddr[10:2];
        wr_data = w_done_q ? wdata_q : s_wdata;
        wr_strb = w_done_q ? wstrb_q : s_wstrb;

        // count_q equals the number of run_pc cycles since START, so it doubles as the limit counter.
        if (running_q) begin
            count_d = count_q + 32'd1;
            if (run_limit_q != 32'd0 && count_d == run_limit_q) begin
                running_d = 1'b0;
                done_d    = 1'b1;
            end
        end
        if (memrst_busy) begin
            memrst_cnt_d = memrst_cnt_q - 8'd1;
        end

        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_done_d = 1'b1;
                    awaddr_d  = s_awaddr[10:2];
                end
                if (w_hs) begin
                    w_done_d = 1'b1;
                    wdata_d  = s_wdata;
                    wstrb_d  = s_wstrb;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    bresp_d   = RESP_OKAY;
                    if (wr_strb != 4'hF) begin
                        bresp_d = RESP_SLVERR;
                    end else if (!wr_addr[8]) begin
                        if (running_q) begin
                            bresp_d = RESP_SLVERR;
                        end else begin
                            imem_wr_d   = 1'b1;
                            imem_data_d = wr_data;
                            imem_addr_d = wr_addr[7:0];
                        end
                    end else begin
                        case (wr_addr[7:0])
                            REG_CTRL: begin
                                if (wr_data[1]) begin
                                    running_d = 1'b0;
                                end else if (wr_data[0] && !running_q && !memrst_busy) begin
                                    count_d     = 32'd0;
                                    done_d      = 1'b0;
                                    running_d   = 1'b1;
                                    run_limit_d = limit_q;
                                end
                                if (wr_data[2] && !running_q && !memrst_busy) begin
                                    memrst_cnt_d = MEMRST_LOAD;
                                end
                            end
                            REG_LIMIT: limit_d = wr_data;
                            default:   bresp_d = RESP_SLVERR;
                        endcase
                    end
                end
            end
            W_RESP: begin
                if (s_bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        awready_d     = (w_state_d == W_IDLE) && !aw_done_d;
        wready_d      = (w_state_d == W_IDLE) && !w_done_d;
        mem_reset_n_d = (memrst_cnt_d == 8'd0);
    end

    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        case (r_state_q)
            R_IDLE: begin
                if (s_arvalid && arready_q) begin
                    r_state_d = R_DATA;
                    rvalid_d  = 1'b1;
                    rdata_d   = 32'd0;
                    rresp_d   = RESP_OKAY;
                    if (!s_araddr[10]) begin
`ifdef LOADER_READBACK_EN
                        rdata_d = shadow_mem[s_araddr[9:2]];
`else
                        rresp_d = RESP_SLVERR;
`endif
                    end else begin
                        case (s_araddr[9:2])
                            REG_CTRL:   rdata_d = 32'd0;
                            REG_STATUS: rdata_d = {29'd0, memrst_busy, done_q, running_q};
                            REG_LIMIT:  rdata_d = limit_q;
                            REG_COUNT:  rdata_d = count_q;
                            default:    rresp_d = RESP_SLVERR;
                        endcase
                    end
                end
            end
            R_DATA: begin
                if (s_rready) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q     <= W_IDLE;
            aw_done_q     <= 1'b0;
            awaddr_q      <= 9'd0;
            w_done_q      <= 1'b0;
            wdata_q       <= 32'd0;
            wstrb_q       <= 4'd0;
            awready_q     <= 1'b0;
            wready_q      <= 1'b0;
            bvalid_q      <= 1'b0;
            bresp_q       <= 2'b00;
            r_state_q     <= R_IDLE;
            arready_q     <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= 32'd0;
            rresp_q       <= 2'b00;
            imem_wr_q     <= 1'b0;
            imem_data_q   <= 32'd0;
            imem_addr_q   <= 8'd0;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            limit_q       <= 32'd0;
            run_limit_q   <= 32'd0;
            count_q       <= 32'd0;
            memrst_cnt_q  <= 8'd0;
            mem_reset_n_q <= 1'b1;
        end else begin
            w_state_q     <= w_state_d;
            aw_done_q     <= aw_done_d;
            awaddr_q      <= awaddr_d;
            w_done_q      <= w_done_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awready_q     <= awready_d;
            wready_q      <= wready_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            r_state_q     <= r_state_d;
            arready_q     <= arready_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            rresp_q       <= rresp_d;
            imem_wr_q     <= imem_wr_d;
            imem_data_q   <= imem_data_d;
            imem_addr_q   <= imem_addr_d;
            running_q     <= running_d;
            done_q        <= done_d;
            limit_q       <= limit_d;
            run_limit_q   <= run_limit_d;
            count_q       <= count_d;
            memrst_cnt_q  <= memrst_cnt_d;
            mem_reset_n_q <= mem_reset_n_d;
        end
    end

    assign s_awready         = awready_q;
    assign s_wready          = wready_q;
    assign s_bvalid          = bvalid_q;
    assign s_bresp           = bresp_q;
    assign s_arready         = arready_q;
    assign s_rvalid          = rvalid_q;
    assign s_rdata           = rdata_q;
    assign s_rresp           = rresp_q;
    assign instruction_write = imem_wr_q;
    assign instruction_data  = imem_data_q;
    assign instruction_addr  = imem_addr_q;
    assign run_pc            = running_q;
    assign mem_reset_n       = mem_reset_n_q;

endmodule

// File: tb/tb_axi4_lite_instr_loader.sv
// Directed bench for axi4_lite_instr_loader: program load, run/stop, limits, errors, MEMRST, back-pressure, reset.
module tb_axi4_lite_instr_loader;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [10:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic        instruction_write;
    logic [31:0] instruction_data;
    logic [7:0]  instruction_addr;
    logic        run_pc;
    logic        mem_reset_n;

    int n_assert = 0;
    int n_fail   = 0;
    int run_cycles = 0;
    int iw_pulses  = 0;
    int mrst_low   = 0;

    axi4_lite_instr_loader #(.MEM_RST_CYCLES(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .s_awaddr          (s_awaddr),
        .s_awvalid         (s_awvalid),
        .s_awready         (s_awready),
        .s_wdata           (s_wdata),
        .s_wstrb           (s_wstrb),
        .s_wvalid          (s_wvalid),
        .s_wready          (s_wready),
        .s_bresp           (s_bresp),
        .s_bvalid          (s_bvalid),
        .s_bready          (s_bready),
        .s_araddr          (s_araddr),
        .s_arvalid         (s_arvalid),
        .s_arready         (s_arready),
        .s_rdata           (s_rdata),
        .s_rresp           (s_rresp),
        .s_rvalid          (s_rvalid),
        .s_rready          (s_rready),
        .instruction_write (instruction_write),
        .instruction_data  (instruction_data),
        .instruction_addr  (instruction_addr),
        .run_pc            (run_pc),
        .mem_reset_n       (mem_reset_n)
    );

    always #5 clk = ~clk;

    // Cycle-level monitor of output pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (run_pc) run_cycles++;
        if (instruction_write) iw_pulses++;
        if (!mem_reset_n) mrst_low++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed time limit reached, required end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: AW and W together; 1: W one cycle before AW; 2: AW one cycle before W.
    task automatic axi_write(input logic [10:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int mode, output logic [1:0] resp, output logic iw, output logic rp);
        bit aw_pend, w_pend, aw_fire, w_fire;
        int k;
        s_awaddr  = addr;
        s_wdata   = data;
        s_wstrb   = strb;
        aw_pend   = 1'b1;
        w_pend    = 1'b1;
        s_wvalid  = (mode != 2);
        s_awvalid = (mode != 1);
        k = 0;
        while ((aw_pend || w_pend) && k < 40) begin
            aw_fire = s_awvalid && s_awready;
            w_fire  = s_wvalid && s_wready;
            tick();
            k++;
            if (aw_fire) begin s_awvalid = 1'b0; aw_pend = 1'b0; end
            if (w_fire)  begin s_wvalid  = 1'b0; w_pend  = 1'b0; end
            if (k == 1 && aw_pend && mode == 1) s_awvalid = 1'b1;
            if (k == 1 && w_pend && mode == 2)  s_wvalid  = 1'b1;
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        check_b("wr_accepted", aw_pend || w_pend, 1'b0);
        check_b("bvalid_latency", s_bvalid, 1'b1);
        resp = s_bresp;
        iw   = instruction_write;
        rp   = run_pc;
        k = 0;
        while (!(s_bvalid && s_bready) && k < 40) begin
            tick();
            k++;
        end
        tick();
    endtask

    task automatic axi_read(input logic [10:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int k;
        s_araddr  = addr;
        s_arvalid = 1'b1;
        k = 0;
        while (!s_arready && k < 40) begin
            tick();
            k++;
        end
        tick();
        s_arvalid = 1'b0;
        check_b("rvalid_latency", s_rvalid, 1'b1);
        data = s_rdata;
        resp = s_rresp;
        k = 0;
        while (!(s_rvalid && s_rready) && k < 40) begin
            tick();
            k++;
        end
        tick();
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic        iw, rp;
        int          b_run, b_iw, b_mrst;

        reset = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b1; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b1;
        repeat (3) tick();

        check_b("rst_awready", s_awready, 1'b0);
        check_b("rst_wready", s_wready, 1'b0);
        check_b("rst_arready", s_arready, 1'b0);
        check_b("rst_bvalid", s_bvalid, 1'b0);
        check_b("rst_rvalid", s_rvalid, 1'b0);
        check_b("rst_run_pc", run_pc, 1'b0);
        check_b("rst_mem_reset_n", mem_reset_n, 1'b1);
        check_b("rst_iwrite", instruction_write, 1'b0);
        check("rst_iaddr", 32'(instruction_addr), 32'd0);
        check("rst_idata", instruction_data, 32'd0);

        reset = 1'b0;
        tick();
        check_b("post_rst_awready", s_awready, 1'b1);
        check_b("post_rst_wready", s_wready, 1'b1);
        check_b("post_rst_arready", s_arready, 1'b1);
        axi_read(11'h404, rd, resp);
        check("rst_status", rd, 32'd0);
        check("rst_status_resp", 32'(resp), 32'(OKAY));
        axi_read(11'h408, rd, resp);
        check("rst_limit", rd, 32'd0);

        // Program load, W before AW, then AW before W at the top of the window.
        b_iw = iw_pulses;
        axi_write(11'h008, 32'h00500093, 4'hF, 1, resp, iw, rp);
        check("imem_resp", 32'(resp), 32'(OKAY));
        check_b("imem_strobe", iw, 1'b1);
        check("imem_addr", 32'(instruction_addr), 32'd2);
        check("imem_data", instruction_data, 32'h00500093);
        check_b("imem_strobe_drop", instruction_write, 1'b0);
        axi_write(11'h3FC, 32'hDEADBEEF, 4'hF, 2, resp, iw, rp);
        check_b("imem_top_strobe", iw, 1'b1);
        check("imem_top_addr", 32'(instruction_addr), 32'h0000_00FF);
        check("imem_top_data", instruction_data, 32'hDEADBEEF);
        check("imem_pulses", 32'(iw_pulses - b_iw), 32'd2);
        axi_read(11'h008, rd, resp);
`ifdef LOADER_READBACK_EN
        check("imem_readback", rd, 32'h00500093);
        check("imem_readback_resp", 32'(resp), 32'(OKAY));
`else
        check("imem_read_zero", rd, 32'd0);
        check("imem_read_resp", 32'(resp), 32'(SLVERR));
`endif

        // Bounded run of 5 cycles.
        axi_write(11'h408, 32'd5, 4'hF, 0, resp, iw, rp);
        check("limit5_resp", 32'(resp), 32'(OKAY));
        b_run = run_cycles;
        axi_write(11'h400, 32'h1, 4'hF, 0, resp, iw, rp);
        check_b("start5_run_with_bvalid", rp, 1'b1);
        repeat (10) tick();
        check_b("run5_ended", run_pc, 1'b0);
        check("run5_cycles", 32'(run_cycles - b_run), 32'd5);
        axi_read(11'h404, rd, resp);
        check("run5_status", rd, 32'h2);
        axi_read(11'h40C, rd, resp);
        check("run5_count", rd, 32'd5);

        // Unbounded run stopped after 20 cycles; limit written mid-run must not apply.
        axi_write(11'h408, 32'd0, 4'hF, 0, resp, iw, rp);
        b_run = run_cycles;
        axi_write(11'h400, 32'h1, 4'hF, 0, resp, iw, rp);
        check_b("start_free_run", rp, 1'b1);
        axi_write(11'h408, 32'd3, 4'hF, 0, resp, iw, rp);
        check("limit_midrun_resp", 32'(resp), 32'(OKAY));
        repeat (16) tick();
        check_b("still_running", run_pc, 1'b1);
        axi_write(11'h400, 32'h2, 4'hF, 0, resp, iw, rp);
        check_b("stop_drops_run_with_bvalid", rp, 1'b0);
        check("stop_resp", 32'(resp), 32'(OKAY));
        check("stop_run_cycles", 32'(run_cycles - b_run), 32'd20);
        axi_read(11'h404, rd, resp);
        check("stop_status", rd, 32'h0);
        axi_read(11'h40C, rd, resp);
        check("stop_count", rd, 32'd20);

        // Limit 3 now active; IMEM write during the run is refused.
        b_run = run_cycles;
        b_iw  = iw_pulses;
        axi_write(11'h400, 32'h1, 4'hF, 0, resp, iw, rp);
        check_b("start3_run", rp, 1'b1);
        axi_write(11'h010, 32'h00000013, 4'hF, 0, resp, iw, rp);
        check("imem_running_resp", 32'(resp), 32'(SLVERR));
        check_b("imem_running_no_strobe", iw, 1'b0);
        repeat (5) tick();
        check("run3_cycles", 32'(run_cycles - b_run), 32'd3);
        axi_read(11'h404, rd, resp);
        check("run3_status", rd, 32'h2);
        axi_read(11'h40C, rd, resp);
        check("run3_count", rd, 32'd3);

        // Error writes with no side effect.
        axi_write(11'h010, 32'h00000013, 4'h3, 0, resp, iw, rp);
        check("partial_strb_resp", 32'(resp), 32'(SLVERR));
        check_b("partial_strb_no_strobe", iw, 1'b0);
        axi_write(11'h500, 32'h1, 4'hF, 0, resp, iw, rp);
        check("unmapped_wr_resp", 32'(resp), 32'(SLVERR));
        axi_write(11'h404, 32'h1, 4'hF, 0, resp, iw, rp);
        check("status_wr_resp", 32'(resp), 32'(SLVERR));
        axi_write(11'h40C, 32'h77, 4'hF, 0, resp, iw, rp);
        check("count_wr_resp", 32'(resp), 32'(SLVERR));
        check_b("ro_write_no_run", rp, 1'b0);
        axi_read(11'h40C, rd, resp);
        check("count_unchanged", rd, 32'd3);
        check("err_no_pulses", 32'(iw_pulses - b_iw), 32'd0);
        check("err_addr_held", 32'(instruction_addr), 32'h0000_00FF);
        axi_read(11'h7FC, rd, resp);
        check("unmapped_rd_data", rd, 32'd0);
        check("unmapped_rd_resp", 32'(resp), 32'(SLVERR));
        axi_read(11'h400, rd, resp);
        check("ctrl_rd_data", rd, 32'd0);
        check("ctrl_rd_resp", 32'(resp), 32'(OKAY));

        // Memory reset pulse; START during it is ignored.
        b_mrst = mrst_low;
        axi_write(11'h400, 32'h4, 4'hF, 0, resp, iw, rp);
        check("memrst_resp", 32'(resp), 32'(OKAY));
        check_b("memrst_low", mem_reset_n, 1'b0);
        axi_read(11'h404, rd, resp);
        check("memrst_status_busy", rd, 32'h6);
        axi_write(11'h400, 32'h1, 4'hF, 0, resp, iw, rp);
        check("start_busy_resp", 32'(resp), 32'(OKAY));
        check_b("start_busy_ignored", rp, 1'b0);
        repeat (4) tick();
        check("memrst_low_cycles", 32'(mrst_low - b_mrst), 32'd4);
        check_b("memrst_released", mem_reset_n, 1'b1);
        check_b("memrst_no_run", run_pc, 1'b0);
        axi_read(11'h404, rd, resp);
        check("memrst_status_after", rd, 32'h2);

        // B channel back-pressure.
        s_bready  = 1'b0;
        s_awaddr  = 11'h408;
        s_wdata   = 32'd7;
        s_wstrb   = 4'hF;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        tick();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        check_b("bhold_bvalid", s_bvalid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_b("bhold_bvalid_stable", s_bvalid, 1'b1);
            check("bhold_bresp_stable", 32'(s_bresp), 32'(OKAY));
            check_b("bhold_no_awready", s_awready, 1'b0);
            check_b("bhold_no_wready", s_wready, 1'b0);
        end
        s_bready = 1'b1;
        tick();
        check_b("bhold_released", s_bvalid, 1'b0);
        check_b("bhold_awready_back", s_awready, 1'b1);
        axi_read(11'h408, rd, resp);
        check("bhold_limit", rd, 32'd7);

        // R channel back-pressure; register changes after the AR handshake must not leak in.
        s_rready  = 1'b0;
        s_araddr  = 11'h408;
        s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        check_b("rhold_rvalid", s_rvalid, 1'b1);
        check("rhold_rdata", s_rdata, 32'd7);
        axi_write(11'h408, 32'h55, 4'hF, 0, resp, iw, rp);
        check("rhold_concurrent_wr", 32'(resp), 32'(OKAY));
        for (int i = 0; i < 8; i++) begin
            tick();
            check_b("rhold_rvalid_stable", s_rvalid, 1'b1);
            check("rhold_rdata_stable", s_rdata, 32'd7);
            check("rhold_rresp_stable", 32'(s_rresp), 32'(OKAY));
            check_b("rhold_no_arready", s_arready, 1'b0);
        end
        s_rready = 1'b1;
        tick();
        check_b("rhold_released", s_rvalid, 1'b0);
        axi_read(11'h408, rd, resp);
        check("rhold_new_limit", rd, 32'h55);

        // START together with STOP: STOP wins.
        axi_write(11'h408, 32'd0, 4'hF, 0, resp, iw, rp);
        axi_write(11'h400, 32'h3, 4'hF, 0, resp, iw, rp);
        check_b("start_stop_no_run", rp, 1'b0);
        axi_read(11'h404, rd, resp);
        check("start_stop_status", rd, 32'h2);

        // Reset in the middle of a run with a half-captured write.
        axi_write(11'h400, 32'h1, 4'hF, 0, resp, iw, rp);
        check_b("pre_reset_run", rp, 1'b1);
        repeat (3) tick();
        s_awaddr  = 11'h00C;
        s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        reset = 1'b1;
        tick();
        check_b("midrst_run_pc", run_pc, 1'b0);
        check_b("midrst_awready", s_awready, 1'b0);
        check_b("midrst_bvalid", s_bvalid, 1'b0);
        check_b("midrst_iwrite", instruction_write, 1'b0);
        reset = 1'b0;
        tick();
        s_wdata  = 32'h12345678;
        s_wstrb  = 4'hF;
        s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        tick();
        check_b("midrst_aw_dropped", s_bvalid, 1'b0);
        check_b("midrst_no_strobe", instruction_write, 1'b0);
        axi_read(11'h40C, rd, resp);
        check("midrst_count", rd, 32'd0);
        axi_read(11'h404, rd, resp);
        check("midrst_status", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_lite_instr_loader.md
# axi4_lite_instr_loader

AXI4-Lite slave that sits directly upstream of the single-cycle RISC-V core and drives its program-load and run controls. It turns host bus writes into instruction-memory write strobes (`instruction_write`, `instruction_data`, `instruction_addr`), provides the memory reset pulse, and gates `run_pc` for a programmable number of cycles. Status and the cycle counter are readable over the same bus.

## Interface
- `MEM_RST_CYCLES`, default 4: number of cycles `mem_reset_n` is held low per request (1..255).
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `s_awaddr` in 11, `s_awvalid` in 1, `s_awready` out 1: write address channel.
- `s_wdata` in 32, `s_wstrb` in 4, `s_wvalid` in 1, `s_wready` out 1: write data channel.
- `s_bresp` out 2, `s_bvalid` out 1, `s_bready` in 1: write response channel.
- `s_araddr` in 11, `s_arvalid` in 1, `s_arready` out 1: read address channel.
- `s_rdata` out 32, `s_rresp` out 2, `s_rvalid` out 1, `s_rready` in 1: read data channel.
- `instruction_write` out 1: one-cycle write strobe to instruction memory.
- `instruction_data` out 32: instruction word, valid with strobe.
- `instruction_addr` out 8: word index, valid with strobe.
- `run_pc` out 1: core PC-advance enable.
- `mem_reset_n` out 1: active-low memory reset pulse.

## Operation
- Address map (byte addresses, word-aligned; `addr[1:0]` ignored):
  - 0x000–0x3FC IMEM window, write-only: word index = `addr[9:2]`.
  - 0x400 CTRL, write: bit0 START, bit1 STOP, bit2 MEMRST. Self-clearing; reads 0.
  - 0x404 STATUS, read-only: bit0 RUNNING, bit1 DONE (sticky), bit2 MEMRST_BUSY.
  - 0x408 CYCLE_LIMIT, read/write, 32 bits; reset value 0.
  - 0x40C CYCLE_COUNT, read-only, 32 bits.
  - 0x410–0x7FC unmapped: SLVERR; reads return 0; writes have no effect.
- Write FSM states: W_IDLE, W_RESP.
  - AW and W are accepted independently, in either order or in the same cycle; each is captured once.
  - `s_awready`/`s_wready` are 1 in W_IDLE until their channel is captured.
  - When both are held, the write executes and the FSM enters W_RESP with `s_bvalid`=1.
  - W_RESP holds until `s_bready`, then returns to W_IDLE. Only one write is outstanding.
- Write errors, SLVERR (2'b10) with no side effect:
  - `s_wstrb` != 4'hF.
  - IMEM write while RUNNING.
  - Write to an unmapped address or to a read-only register.
  - All other writes return OKAY (2'b00).
- IMEM write: `instruction_write`=1 for exactly one cycle; `instruction_data`/`instruction_addr` are registered and hold until the next IMEM write.
- START:
  - If not RUNNING and MEMRST_BUSY=0: clear CYCLE_COUNT and DONE, set RUNNING.
  - Otherwise ignored, response OKAY.
- STOP: clears RUNNING; DONE is not set. If START and STOP are written together, STOP wins.
- While RUNNING, CYCLE_COUNT increments once per `run_pc` cycle (32-bit, wraps).
  - CYCLE_LIMIT=N>0: `run_pc` is high for exactly N cycles, then RUNNING clears and DONE sets.
  - CYCLE_LIMIT=0: runs until STOP.
  - Writing CYCLE_LIMIT while RUNNING takes effect at the next START.
- MEMRST: if not RUNNING, `mem_reset_n`=0 for MEM_RST_CYCLES cycles and MEMRST_BUSY=1. Ignored while RUNNING or already busy.
- Read FSM states: R_IDLE, R_DATA.
  - `s_arready`=1 in R_IDLE.
  - After the AR handshake, `s_rvalid`=1 with data and response; held stable until `s_rready`.
  - An IMEM window read returns 0 with SLVERR (see Configuration).
- The read and write FSMs are independent and may complete in the same cycle.

## Timing
- Reset values (while `reset`=1 and the cycle after): all `s_*ready`/`s_*valid`=0, `s_bresp`/`s_rresp`/`s_rdata`=0, `instruction_write`=0, `instruction_data`=0, `instruction_addr`=0, `run_pc`=0, `mem_reset_n`=1, all registers 0. Ready signals rise the first cycle after `reset` falls.
- Write latency: the side effect (`instruction_write`, START/STOP/MEMRST) and `s_bvalid` appear in the cycle after the later of the AW/W handshakes.
- `run_pc` rises in the same cycle `s_bvalid` rises for START and falls in the same cycle for STOP.
- Read latency: `s_rvalid` rises 1 cycle after the AR handshake. Reads reflect register state at the handshake edge.
- `reset` asserted mid-transaction aborts it: no response, `run_pc` and `instruction_write` drop on that edge.

## Configuration
- `LOADER_READBACK_EN` defined:
  - A 256×32 shadow RAM is written alongside every successful IMEM write.
  - IMEM window reads return the shadow word with OKAY; read latency is unchanged.
  - Shadow contents are not reset.
- `LOADER_READBACK_EN` undefined: no shadow RAM; IMEM window reads return 0 with SLVERR.

## Test plan
- Write 0x00500093 to 0x008, W one cycle before AW → one-cycle `instruction_write`, `instruction_addr`=2, `instruction_data`=0x00500093, `s_bresp`=OKAY; with `LOADER_READBACK_EN`, read of 0x008 returns 0x00500093.
- CYCLE_LIMIT=5, then CTRL=0x1 → `run_pc` high exactly 5 cycles; STATUS=0x2; CYCLE_COUNT=5.
- CYCLE_LIMIT=0, START, STOP after 20 cycles → `run_pc` drops with STOP's `s_bvalid`; DONE=0; CYCLE_COUNT=20.
- IMEM write while RUNNING, `s_wstrb`=4'h3, and write to 0x500 → each returns SLVERR with no `instruction_write`.
- MEMRST with MEM_RST_CYCLES=4 → `mem_reset_n` low 4 cycles, STATUS bit2=1 during; START issued meanwhile is ignored.
- Hold `s_bready`/`s_rready` low 10 cycles → `s_bvalid`/`s_rvalid` and payloads stable; no new AW/W accepted until B completes.
